alu_uart_sequencer: RTL and testbench

//   Sequences the shared ALU for the UART command path, and frames each transaction.

---
 rtl/alu_uart_sequencer_pkg.sv | 29 ++
 rtl/alu_uart_sequencer_if.sv | 62 ++++++
 rtl/alu_uart_sequencer_timeout_counter.sv | 35 +++
 rtl/alu_uart_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_alu_uart_sequencer.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_uart_sequencer_pkg.sv
// alu_uart_sequencer_pkg
//   Shared definitions for the UART command-path sequencer: default widths,
//   ALU opcode constants and the one-hot sequencer state type.
//   No ports (package).
package alu_uart_sequencer_pkg;

    localparam int unsigned DefSizeData = 8;
    localparam int unsigned DefSizeOp   = 6;

    // ALU opcodes as carried in the low bits of the third frame byte
    localparam logic [5:0] OpAdd = 6'b100000;
    localparam logic [5:0] OpSub = 6'b100010;
    localparam logic [5:0] OpAnd = 6'b100100;

    typedef enum logic [5:0] {
        StGetA   = 6'b000001,
        StGetB   = 6'b000010,
        StGetOp  = 6'b000100,
        StExec   = 6'b001000,
        StSend   = 6'b010000,
        StWaitTx = 6'b100000
    } state_e;

    // States in which incoming RX bytes cannot be accepted
    function automatic logic is_busy_state(state_e s);
        return (s == StExec) || (s == StSend) || (s == StWaitTx);
    endfunction

endpackage

// File: rtl/alu_uart_sequencer_if.sv
// alu_uart_sequencer_if
//   Bundles the sequencer's RX, ALU and TX side signals.
//   master: the sequencer (consumes RX/ALU/TX-done, drives operands, TX and status).
//   slave : the surrounding uart_rx / ALU / uart_tx environment.
//   Signals:
//     i_rx_done, i_rx_data     RX byte strobe and data
//     i_alu_result             combinational ALU result
//     i_tx_done                TX byte finished strobe
//     o_alu_datoa/datob/opcode registered ALU operands and opcode
//     o_tx_data, o_tx_start    result byte and TX start strobe
//     o_busy                   frame being executed/transmitted
//     o_timeout_err            partial frame aborted strobe
//     o_overrun_err            RX byte dropped strobe
interface alu_uart_sequencer_if #(
    parameter int unsigned SIZEDATA = 8,
    parameter int unsigned SIZEOP   = 6
);

    logic                i_rx_done;
    logic [SIZEDATA-1:0] i_rx_data;
    logic [SIZEDATA-1:0] i_alu_result;
    logic                i_tx_done;
    logic [SIZEDATA-1:0] o_alu_datoa;
    logic [SIZEDATA-1:0] o_alu_datob;
    logic [SIZEOP-1:0]   o_alu_opcode;
    logic [SIZEDATA-1:0] o_tx_data;
    logic                o_tx_start;
    logic                o_busy;
    logic                o_timeout_err;
    logic                o_overrun_err;

    modport master (
        input  i_rx_done,
        input  i_rx_data,
        input  i_alu_result,
        input  i_tx_done,
        output o_alu_datoa,
        output o_alu_datob,
        output o_alu_opcode,
        output o_tx_data,
        output o_tx_start,
        output o_busy,
        output o_timeout_err,
        output o_overrun_err
    );

    modport slave (
        output i_rx_done,
        output i_rx_data,
        output i_alu_result,
        output i_tx_done,
        input  o_alu_datoa,
        input  o_alu_datob,
        input  o_alu_opcode,
        input  o_tx_data,
        input  o_tx_start,
        input  o_busy,
        input  o_timeout_err,
        input  o_overrun_err
    );

endinterface

// File: rtl/alu_uart_sequencer_timeout_counter.sv
// alu_uart_sequencer_timeout_counter
//   Idle-cycle watchdog. Counts enabled cycles since the last clear and flags
//   expiry once TIMEOUT-1 is reached (i.e. on the TIMEOUT-th idle cycle).
//   Ports:
//     i_clock, i_reset  clock, synchronous active-high reset
//     i_clear           reset the count to zero (has priority over enable)
//     i_enable          count this cycle
//     o_expired         count has reached TIMEOUT-1
module alu_uart_sequencer_timeout_counter #(
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] r_count;

    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            // Saturate so a held-off consumer never sees the count wrap
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == CntMax);

endmodule

// File: rtl/alu_uart_sequencer.sv
// alu_uart_sequencer
//   Frames UART command transactions for the shared ALU: collects operand A,
//   operand B and opcode bytes, holds them on the ALU for ALU_LAT cycles,
//   samples the result and hands it to UART TX with a start/done handshake.
//   Partial frames are aborted after TIMEOUT idle cycles; bytes arriving while
//   a frame is executing or transmitting are dropped and flagged.
//   Ports:
//     i_clock  system clock
//     i_reset  synchronous, active-high reset
//     bus      alu_uart_sequencer_if.master (RX, ALU, TX and status signals)
module alu_uart_sequencer
    import alu_uart_sequencer_pkg::*;
#(
    parameter int unsigned SIZEDATA = DefSizeData,
    parameter int unsigned SIZEOP   = DefSizeOp,
    parameter int unsigned ALU_LAT  = 1,
    parameter int unsigned TIMEOUT  = 1000
) (
    input logic                  i_clock,
    input logic                  i_reset,
    alu_uart_sequencer_if.master bus
);

    localparam int unsigned ExecW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [ExecW-1:0] ExecLast = ExecW'(ALU_LAT - 1);

    state_e w_state_next;
    state_e r_state;

    logic                r_busy;
    logic                r_tx_start;
    logic                r_timeout_err;
    logic                r_overrun_err;
    logic                r_overrun_pend;
    logic [SIZEDATA-1:0] r_datoa;
    logic [SIZEDATA-1:0] r_datob;
    logic [SIZEOP-1:0]   r_opcode;
    logic [SIZEDATA-1:0] r_tx_data;
    logic [ExecW-1:0]    r_exec_cnt;

    logic w_in_frame;
    logic w_expired;
    logic w_load_a;
    logic w_load_b;
    logic w_load_op;
    logic w_sample;
    logic w_start;
    logic w_timeout;
    logic w_overrun;
    logic w_overrun_defer;

    assign w_in_frame = (r_state == StGetB) || (r_state == StGetOp);

    // Cleared by every accepted byte and whenever no partial frame is open,
    // so it always restarts from zero on entry to GET_B.
    alu_uart_sequencer_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_clear   (bus.i_rx_done || !w_in_frame),
        .i_enable  (w_in_frame),
        .o_expired (w_expired)
    );

    // State register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= StGetA;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and datapath strobes
    always_comb begin
        w_state_next    = r_state;
        w_load_a        = 1'b0;
        w_load_b        = 1'b0;
        w_load_op       = 1'b0;
        w_sample        = 1'b0;
        w_start         = 1'b0;
        w_timeout       = 1'b0;
        w_overrun       = 1'b0;
        w_overrun_defer = 1'b0;

        unique case (r_state)
            StGetA: begin
                if (bus.i_rx_done) begin
                    w_load_a     = 1'b1;
                    w_state_next = StGetB;
                end
            end
            StGetB: begin
                // A byte arriving on the expiry cycle still counts
                if (bus.i_rx_done) begin
                    w_load_b     = 1'b1;
                    w_state_next = StGetOp;
                end else if (w_expired) begin
                    w_timeout    = 1'b1;
                    w_state_next = StGetA;
                end
            end
            StGetOp: begin
                if (bus.i_rx_done) begin
                    w_load_op    = 1'b1;
                    w_state_next = StExec;
                end else if (w_expired) begin
                    w_timeout    = 1'b1;
                    w_state_next = StGetA;
                end
            end
            StExec: begin
                w_overrun = bus.i_rx_done;
                if (r_exec_cnt == ExecLast) begin
                    w_sample     = 1'b1;
                    w_state_next = StSend;
                end
            end
            StSend: begin
                // The overrun pulse would coincide with o_tx_start; push it a cycle later
                w_overrun_defer = bus.i_rx_done;
                w_start         = 1'b1;
                w_state_next    = StWaitTx;
            end
            StWaitTx: begin
                w_overrun = bus.i_rx_done;
                if (bus.i_tx_done) begin
                    w_state_next = StGetA;
                end
            end
            default: begin
                w_state_next = StGetA;
            end
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_busy         <= 1'b0;
            r_tx_start     <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_overrun_err  <= 1'b0;
            r_overrun_pend <= 1'b0;
            r_datoa        <= '0;
            r_datob        <= '0;
            r_opcode       <= '0;
            r_tx_data      <= '0;
            r_exec_cnt     <= '0;
        end else begin
            r_busy         <= is_busy_state(w_state_next);
            r_tx_start     <= w_start;
            r_timeout_err  <= w_timeout;
            // A deferred drop and a fresh one in the next cycle merge into one pulse
            r_overrun_err  <= w_overrun || r_overrun_pend;
            r_overrun_pend <= w_overrun_defer;

            if (w_load_a) begin
                r_datoa <= bus.i_rx_data;
            end
            if (w_load_b) begin
                r_datob <= bus.i_rx_data;
            end
            if (w_load_op) begin
                r_opcode   <= bus.i_rx_data[SIZEOP-1:0];
                r_exec_cnt <= '0;
            end else if (r_state == StExec) begin
                r_exec_cnt <= r_exec_cnt + 1'b1;
            end
            if (w_sample) begin
                r_tx_data <= bus.i_alu_result;
            end
        end
    end

    assign bus.o_alu_datoa   = r_datoa;
    assign bus.o_alu_datob   = r_datob;
    assign bus.o_alu_opcode  = r_opcode;
    assign bus.o_tx_data     = r_tx_data;
    assign bus.o_tx_start    = r_tx_start;
    assign bus.o_busy        = r_busy;
    assign bus.o_timeout_err = r_timeout_err;
    assign bus.o_overrun_err = r_overrun_err;

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// tb_alu_uart_sequencer
//   Self-checking bench for alu_uart_sequencer. Stimulus pushes expected TX
//   transactions and error pulses (with their expected cycles) into queues; a
//   negedge monitor pops and compares whenever the DUT raises a strobe.
module tb_alu_uart_sequencer;
    import alu_uart_sequencer_pkg::*;

    localparam int unsigned AluLat  = 2;
    localparam int unsigned Timeout = 1000;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
        logic [7:0] tx;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_uart_sequencer_if #(.SIZEDATA(8), .SIZEOP(6)) bus ();

    alu_uart_sequencer #(
        .SIZEDATA (8),
        .SIZEOP   (6),
        .ALU_LAT  (AluLat),
        .TIMEOUT  (Timeout)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    // Simple ALU model driven from the DUT's registered operands
    always_comb begin
        case (bus.o_alu_opcode)
            OpAdd:   bus.i_alu_result = bus.o_alu_datoa + bus.o_alu_datob;
            OpSub:   bus.i_alu_result = bus.o_alu_datoa - bus.o_alu_datob;
            OpAnd:   bus.i_alu_result = bus.o_alu_datoa & bus.o_alu_datob;
            default: bus.i_alu_result = 8'h00;
        endcase
    end

    exp_t tx_q[$];
    int   to_q[$];
    int   ov_q[$];
    exp_t mon_e;
    int   mon_c;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_rx = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, int got, int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    // Monitor: compare every strobe the DUT raises against the queues
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.o_tx_start) begin
                check("start_err_overlap", {bus.o_timeout_err, bus.o_overrun_err}, 0);
                if (tx_q.size() == 0) begin
                    check("unexpected_tx_start", 1, 0);
                end else begin
                    mon_e = tx_q.pop_front();
                    check("tx_data", bus.o_tx_data, mon_e.tx);
                    check("alu_datoa", bus.o_alu_datoa, mon_e.a);
                    check("alu_datob", bus.o_alu_datob, mon_e.b);
                    check("alu_opcode", bus.o_alu_opcode, mon_e.op);
                    check("tx_start_cycle", cyc, mon_e.cyc);
                end
            end
            if (bus.o_timeout_err) begin
                if (to_q.size() == 0) begin
                    check("unexpected_timeout_err", 1, 0);
                end else begin
                    mon_c = to_q.pop_front();
                    check("timeout_err_cycle", cyc, mon_c);
                end
            end
            if (bus.o_overrun_err) begin
                if (ov_q.size() == 0) begin
                    check("unexpected_overrun_err", 1, 0);
                end else begin
                    mon_c = ov_q.pop_front();
                    check("overrun_err_cycle", cyc, mon_c);
                end
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge
    task automatic idle(int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(logic [7:0] b);
        bus.i_rx_data = b;
        bus.i_rx_done = 1'b1;
        last_rx = cyc;
        idle(1);
        bus.i_rx_done = 1'b0;
    endtask

    task automatic expect_tx(logic [7:0] a, logic [7:0] b, logic [5:0] op, logic [7:0] tx);
        exp_t e;
        e.a   = a;
        e.b   = b;
        e.op  = op;
        e.tx  = tx;
        e.cyc = last_rx + AluLat + 2;
        tx_q.push_back(e);
    endtask

    task automatic frame(logic [7:0] a, logic [7:0] b, logic [7:0] opb,
                         logic [5:0] exp_op, logic [7:0] exp_tx, int gap);
        send(a);
        idle(gap - 1);
        send(b);
        idle(gap - 1);
        send(opb);
        expect_tx(a, b, exp_op, exp_tx);
    endtask

    task automatic wait_start();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.o_tx_start) seen = 1'b1;
            else idle(1);
        end
        if (!seen) check("tx_start_wait", 0, 1);
    endtask

    task automatic finish_tx();
        idle(2);
        check("busy_in_wait_tx", bus.o_busy, 1);
        bus.i_tx_done = 1'b1;
        idle(1);
        bus.i_tx_done = 1'b0;
        check("busy_after_tx_done", bus.o_busy, 0);
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_datoa"}, bus.o_alu_datoa, 0);
        check({tag, "_datob"}, bus.o_alu_datob, 0);
        check({tag, "_opcode"}, bus.o_alu_opcode, 0);
        check({tag, "_tx_data"}, bus.o_tx_data, 0);
        check({tag, "_strobes"}, {bus.o_tx_start, bus.o_busy,
                                  bus.o_timeout_err, bus.o_overrun_err}, 0);
    endtask

    initial begin
        bus.i_rx_done = 1'b0;
        bus.i_rx_data = 8'h00;
        bus.i_tx_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        check_all_zero("reset");

        // ADD at one byte every 50 cycles
        frame(8'h05, 8'h03, 8'h20, 6'h20, 8'h08, 50);
        wait_start();
        finish_tx();

        // SUB wraps below zero
        frame(8'h05, 8'h07, 8'h22, 6'h22, 8'hFE, 3);
        wait_start();
        finish_tx();

        // Upper opcode bits dropped: 0xE4 -> AND
        frame(8'h0F, 8'h3C, 8'hE4, 6'h24, 8'h0C, 3);
        wait_start();
        finish_tx();

        // Partial frame abort after TIMEOUT idle cycles
        send(8'h11);
        to_q.push_back(last_rx + Timeout + 1);
        idle(Timeout + 3);
        check("timeout_keeps_datoa", bus.o_alu_datoa, 8'h11);
        check("timeout_keeps_datob", bus.o_alu_datob, 8'h3C);
        check("timeout_not_busy", bus.o_busy, 0);
        frame(8'h02, 8'h02, 8'h20, 6'h20, 8'h04, 3);
        wait_start();
        finish_tx();

        // Byte on the exact expiry cycle is accepted
        send(8'h21);
        idle(Timeout - 1);
        send(8'h22);
        idle(10);
        send(8'h20);
        expect_tx(8'h21, 8'h22, 6'h20, 8'h43);
        wait_start();
        finish_tx();

        // Byte during WAIT_TX is dropped and flagged
        frame(8'h01, 8'h02, 8'h20, 6'h20, 8'h03, 3);
        wait_start();
        idle(1);
        send(8'hAA);
        ov_q.push_back(last_rx + 1);
        check("overrun_datoa_kept", bus.o_alu_datoa, 8'h01);
        finish_tx();
        frame(8'h10, 8'h20, 8'h20, 6'h20, 8'h30, 3);
        wait_start();
        finish_tx();

        // Reset during EXEC discards the frame
        send(8'h09);
        send(8'h09);
        send(8'h20);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check_all_zero("exec_reset");
        idle(8);
        frame(8'h07, 8'h01, 8'h22, 6'h22, 8'h06, 3);
        wait_start();
        finish_tx();

        // Stray tx_done while collecting is ignored
        send(8'h31);
        bus.i_tx_done = 1'b1;
        idle(1);
        bus.i_tx_done = 1'b0;
        idle(1);
        send(8'h15);
        idle(2);
        send(8'h24);
        expect_tx(8'h31, 8'h15, 6'h24, 8'h11);
        wait_start();
        finish_tx();

        idle(5);
        check("tx_queue_drained", tx_q.size(), 0);
        check("timeout_queue_drained", to_q.size(), 0);
        check("overrun_queue_drained", ov_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog at cycle %0d: got=running exp=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
